// File: rtl/muldiv_ctl_pkg.sv
// rtl/muldiv_ctl_pkg.sv - opcode and state encodings for the multiply/divide sequencer
package muldiv_ctl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_CALC  = 2'b01,
    MD_FIXUP = 2'b10
  } md_state_t;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctl_if.sv
// rtl/muldiv_ctl_if.sv - execute-stage request and HI/LO result bundle
interface muldiv_ctl_if #(parameter int WIDTH = 32);
  logic             Start_EX;
  logic [1:0]       MdOp_EX;
  logic [WIDTH-1:0] SrcA_EX;
  logic [WIDTH-1:0] SrcB_EX;
  logic             WrHi_EX;
  logic             WrLo_EX;
  logic             RdHiLo_EX;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy_MD;
  logic             Stall_MD;

  modport master (
    output Start_EX, MdOp_EX, SrcA_EX, SrcB_EX, WrHi_EX, WrLo_EX, RdHiLo_EX,
    input  Hi, Lo, Busy_MD, Stall_MD
  );

  modport slave (
    input  Start_EX, MdOp_EX, SrcA_EX, SrcB_EX, WrHi_EX, WrLo_EX, RdHiLo_EX,
    output Hi, Lo, Busy_MD, Stall_MD
  );
endinterface

// File: rtl/muldiv_ctl_iter.sv
// rtl/muldiv_ctl_iter.sv - one radix-2 step: shift-add multiply or restoring divide
module muldiv_ctl_iter #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] top;
  logic [WIDTH:0] diff;

  always_comb begin
    // mul: acc = {partial product, remaining multiplier bits}
    sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    // div: acc = {remainder, dividend bits / quotient bits}, shifted left by one
    top  = acc_in[2*WIDTH-1:WIDTH-1];
    diff = top - {1'b0, operand};
    if (is_div) begin
      if (!diff[WIDTH])
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      else
        acc_out = {top[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctl.sv
// rtl/muldiv_ctl.sv - iterative MULT/DIV sequencer with HI/LO and hazard stall
module muldiv_ctl
  import muldiv_ctl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  muldiv_ctl_if.slave md
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic               busy;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_ctl_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div  (is_div),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (acc_nxt)
  );

  always_comb begin
    signed_op = md_is_signed(md.MdOp_EX);
    abs_a     = (signed_op && md.SrcA_EX[WIDTH-1]) ? -md.SrcA_EX : md.SrcA_EX;
    abs_b     = (signed_op && md.SrcB_EX[WIDTH-1]) ? -md.SrcB_EX : md.SrcB_EX;
    prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
    // a zero divisor leaves the dividend in the remainder, so sign restore yields SrcA
    quot_fix  = div_zero ? '1 : ((sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (!flush) begin
            if (md.Start_EX) begin
              state    <= MD_CALC;
              busy     <= 1'b1;
              cnt      <= '0;
              acc      <= {{WIDTH{1'b0}}, abs_a};
              opnd     <= abs_b;
              is_div   <= md_is_div(md.MdOp_EX);
              sign_a   <= signed_op & md.SrcA_EX[WIDTH-1];
              sign_b   <= signed_op & md.SrcB_EX[WIDTH-1];
              div_zero <= (md.SrcB_EX == '0);
            end else begin
              if (md.WrHi_EX) hi <= md.SrcA_EX;
              if (md.WrLo_EX) lo <= md.SrcA_EX;
            end
          end
        end
        MD_CALC: begin
          if (flush) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
              state <= MD_FIXUP;
          end
        end
        MD_FIXUP: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md.Hi       = hi;
  assign md.Lo       = lo;
  assign md.Busy_MD  = busy;
  assign md.Stall_MD = busy & (md.Start_EX | md.RdHiLo_EX | md.WrHi_EX | md.WrLo_EX);

endmodule

// File: tb/tb_muldiv_ctl.sv
// tb/tb_muldiv_ctl.sv - randomized self-checking bench for muldiv_ctl
module tb_muldiv_ctl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  muldiv_ctl_if #(.WIDTH(W)) md ();

  muldiv_ctl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .md    (md)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] hi_m;
  logic [W-1:0] lo_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    md.Start_EX  = 1'b0;
    md.WrHi_EX   = 1'b0;
    md.WrLo_EX   = 1'b0;
    md.RdHiLo_EX = 1'b0;
  endtask

  // Architectural result of each opcode, straight from the arithmetic definition.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    int n;
    logic [63:0] r;
    logic exp_stall;
    md.Start_EX = 1'b1;
    md.MdOp_EX  = op;
    md.SrcA_EX  = a;
    md.SrcB_EX  = b;
    tick();
    md.Start_EX = 1'b0;
    check("busy_after_start", 64'(md.Busy_MD), 64'd1);
    n = 0;
    while (md.Busy_MD && n < 100) begin
      if (noise) begin
        md.Start_EX  = 1'($urandom_range(0, 1));
        md.WrHi_EX   = 1'($urandom_range(0, 1));
        md.WrLo_EX   = 1'($urandom_range(0, 1));
        md.RdHiLo_EX = 1'($urandom_range(0, 1));
        md.MdOp_EX   = 2'($urandom_range(0, 3));
        md.SrcA_EX   = $urandom;
        md.SrcB_EX   = $urandom;
        exp_stall = md.Start_EX | md.WrHi_EX | md.WrLo_EX | md.RdHiLo_EX;
        #1;
        check("stall_while_busy", 64'(md.Stall_MD), 64'(exp_stall));
      end
      tick();
      n++;
    end
    clear_inputs();
    check("latency", 64'(n), 64'd33);
    r = model(op, a, b);
    hi_m = r[63:32];
    lo_m = r[31:0];
    check("hi", 64'(md.Hi), 64'(hi_m));
    check("lo", 64'(md.Lo), 64'(lo_m));
  endtask

  task automatic mt(input bit to_hi, input logic [W-1:0] v);
    md.WrHi_EX = to_hi;
    md.WrLo_EX = !to_hi;
    md.SrcA_EX = v;
    #1;
    check("mt_stall_idle", 64'(md.Stall_MD), 64'd0);
    tick();
    clear_inputs();
    if (to_hi) hi_m = v; else lo_m = v;
    check("mt_hi", 64'(md.Hi), 64'(hi_m));
    check("mt_lo", 64'(md.Lo), 64'(lo_m));
    check("mt_busy", 64'(md.Busy_MD), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    flush = 1'b0;
    md.MdOp_EX = 2'b00;
    md.SrcA_EX = '0;
    md.SrcB_EX = '0;
    clear_inputs();
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(md.Hi), 64'd0);
    check("rst_lo", 64'(md.Lo), 64'd0);
    check("rst_busy", 64'(md.Busy_MD), 64'd0);
    check("rst_stall", 64'(md.Stall_MD), 64'd0);
    reset = 1'b0;
    tick();

    mt(1'b1, 32'hDEAD_BEEF);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", 64'(md.Hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo", 64'(md.Lo), 64'h0000_0000_0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo", 64'(md.Lo), 64'h0000_0000_FFFF_FFFD);
    run_op(2'b11, 32'd7, 32'd0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF3, 32'd0, 1'b1);

    // RdHiLo held behind a multiply: stall lasts until the result is visible
    md.Start_EX = 1'b1;
    md.MdOp_EX  = 2'b01;
    md.SrcA_EX  = 32'd2;
    md.SrcB_EX  = 32'd3;
    tick();
    md.Start_EX  = 1'b0;
    md.RdHiLo_EX = 1'b1;
    #1;
    n = 0;
    while (md.Stall_MD && n < 100) begin
      tick();
      n++;
    end
    clear_inputs();
    hi_m = '0;
    lo_m = 32'd6;
    check("rd_stall_cycles", 64'(n), 64'd33);
    check("rd_stall_lo", 64'(md.Lo), 64'(lo_m));

    // flush during CALC
    mt(1'b1, 32'h1111_1111);
    mt(1'b0, 32'h2222_2222);
    md.Start_EX = 1'b1;
    md.MdOp_EX  = 2'b11;
    md.SrcA_EX  = 32'd100;
    md.SrcB_EX  = 32'd7;
    tick();
    md.Start_EX = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_calc_busy", 64'(md.Busy_MD), 64'd0);
    check("flush_calc_hi", 64'(md.Hi), 64'(hi_m));
    check("flush_calc_lo", 64'(md.Lo), 64'(lo_m));

    // flush on the FIXUP edge
    md.Start_EX = 1'b1;
    md.MdOp_EX  = 2'b01;
    md.SrcA_EX  = 32'd9;
    md.SrcB_EX  = 32'd9;
    tick();
    md.Start_EX = 1'b0;
    repeat (32) tick();
    check("fixup_busy_pre", 64'(md.Busy_MD), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_fixup_busy", 64'(md.Busy_MD), 64'd0);
    check("flush_fixup_lo", 64'(md.Lo), 64'(lo_m));

    // flush suppresses launch and MTHI in IDLE
    flush = 1'b1;
    md.Start_EX = 1'b1;
    tick();
    md.Start_EX = 1'b0;
    md.WrHi_EX  = 1'b1;
    md.SrcA_EX  = 32'hCAFE_F00D;
    tick();
    flush = 1'b0;
    clear_inputs();
    check("flush_start_busy", 64'(md.Busy_MD), 64'd0);
    check("flush_mthi_hi", 64'(md.Hi), 64'(hi_m));

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), $urandom);
      else run_op(2'($urandom_range(0, 3)), pick(), pick(), (i % 6) == 0);
    end

    // asynchronous reset during CALC
    md.Start_EX = 1'b1;
    md.MdOp_EX  = 2'b00;
    md.SrcA_EX  = 32'd12345;
    md.SrcB_EX  = 32'd678;
    tick();
    md.Start_EX = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_hi", 64'(md.Hi), 64'd0);
    check("async_rst_lo", 64'(md.Lo), 64'd0);
    check("async_rst_busy", 64'(md.Busy_MD), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_busy", 64'(md.Busy_MD), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctl.md
Name: muldiv_ctl

Overview:
- Iterative multiply/divide sequencer with HI/LO registers. Sits beside the execute-stage ALU and serves the MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO opcodes.
- Sequences a radix-2 shift-add or restoring-subtract datapath over WIDTH cycles.
- Raises Stall_MD to the hazard logic while a dependent instruction must wait.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of the in-flight operation (branch redirect)
- Start_EX  in  1  launch the operation in MdOp_EX
- MdOp_EX  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcA_EX  in  WIDTH  multiplicand / dividend (bypassed value)
- SrcB_EX  in  WIDTH  multiplier / divisor (bypassed value)
- WrHi_EX  in  1  MTHI request
- WrLo_EX  in  1  MTLO request
- RdHiLo_EX  in  1  MFHI/MFLO in EX this cycle
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register
- Busy_MD  out  1  operation in flight
- Stall_MD  out  1  combinational stall request to the hazard unit

Behaviour:
- Reset (async, active-high): state IDLE, Hi=0, Lo=0, Busy_MD=0, iteration counter=0, internal accumulators=0.
- States:
  - IDLE
  - CALC: counter runs 0..WIDTH-1
  - FIXUP: sign correction and HI/LO commit
- IDLE -> CALC on an edge with Start_EX=1 and flush=0 (edge E0). Operands are latched at that edge:
  - Signed ops latch absolute values plus sign flags.
  - Unsigned ops latch the raw values.
- CALC performs one iteration per edge (E1..E32 for WIDTH=32). On the edge where counter=WIDTH-1 the state goes to FIXUP.
  - Multiply: 2*WIDTH product accumulator, add-then-shift-right.
  - Divide: restoring shift-left-subtract, one quotient bit per cycle.
- FIXUP (edge E33) writes Hi/Lo and returns to IDLE.
  - MULT: negate the 64-bit product if signA^signB.
  - DIV: quotient negated if signA^signB; remainder takes the sign of the dividend (truncation toward zero).
- Latency: Busy_MD=1 from after E0 until E33, i.e. 33 cycles for WIDTH=32. New Hi/Lo are visible in the cycle after E33.
- Stall_MD = Busy_MD & (Start_EX | RdHiLo_EX | WrHi_EX | WrLo_EX). It is zero when idle.
- Start_EX while Busy_MD=1 is ignored; the hazard unit holds the instruction via Stall_MD.
- MTHI/MTLO in IDLE: Hi <= SrcA_EX (resp. Lo) on the next edge, one cycle, Busy_MD stays 0.
- MTHI/MTLO while busy: write ignored, stall raised.
- Start_EX with WrHi_EX/WrLo_EX in the same cycle: Start wins and the write is dropped. The decoder never issues both.
- Divide by zero (SrcB=0, signed or unsigned): full latency is still taken; result is Hi=original SrcA, Lo={WIDTH{1}}.
- DIV of -2^(WIDTH-1) by -1: Lo=0x80000000, Hi=0. No trap.
- flush=1 in CALC or FIXUP: state returns to IDLE on that edge, Busy_MD=0 next cycle, Hi/Lo keep their previous values.
- flush together with Start_EX in IDLE: no launch.
- flush together with MTHI/MTLO: the write is dropped.
- Reset mid-operation: immediate IDLE and Hi=Lo=0, regardless of clk.
- Back-to-back: a Start_EX in the cycle after E33 launches normally. No dead cycle is required.

Decomposition:
- Shared header md_defs.vh holds:
  - MdOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - state encodings (MD_IDLE, MD_CALC, MD_FIXUP)
  - the divide-by-zero quotient constant
- Sub-module md_iter is natural: the combinational single-iteration datapath (add/shift for mul, subtract/compare/shift for div) selected by a mul/div flag. muldiv_ctl owns the FSM, counter, sign flags, HI/LO and stall logic.
- Registers use the existing dff with flush where a synchronous clear is wanted. FSM/HI/LO flops are written with async reset.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> Busy_MD high for 33 cycles; then Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT -3*5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Immediately followed by DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF, with no dead cycle between operations.
- DIVU 7/0 -> Hi=0x00000007, Lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MULTU 2*3, then RdHiLo_EX held from the next cycle -> Stall_MD=1 for 33 cycles, drops to 0 in the cycle Lo=6 is visible.
- DIVU 100/7 with flush at cycle 10 -> Busy_MD=0 at cycle 11; Hi/Lo unchanged from their prior values (preload 0x11111111/0x22222222 via MTHI/MTLO).
- MTHI 0xDEADBEEF in IDLE -> Hi=0xDEADBEEF next cycle, Stall_MD=0. Assert reset during CALC -> Hi=Lo=0, Busy_MD=0 asynchronously.
